// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the datapath: IR/Stop in, every strobe out.
interface control_sequencer_if #(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
);
  logic [31:0]         ir;
  logic                stop;
  logic [NUM_REGS-1:0] rin;
  logic [NUM_REGS-1:0] rout;
  logic                pc_out;
  logic                mar_in;
  logic                inc_pc;
  logic                read;
  logic                mdr_in;
  logic                mdr_out;
  logic                ir_in;
  logic                y_in;
  logic                zhigh_in;
  logic                zlow_in;
  logic                zhigh_out;
  logic                zlow_out;
  logic                hi_in;
  logic                lo_in;
  logic [OPW-1:0]      op;
  logic                run;
  logic                illegal;

  modport master (
    input  ir, stop,
    output rin, rout, pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in,
           zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, op, run, illegal
  );

  modport slave (
    output ir, stop,
    input  rin, rout, pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in, y_in,
           zhigh_in, zlow_in, zhigh_out, zlow_out, hi_in, lo_in, op, run, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: a registered T-state machine whose strobes are a Moore
// decode of the current state and the IR held by the datapath.
module control_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPW      = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, HLT
  } state_t;

  state_t state, state_next;
  logic   stop_latched;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv, is_nop, is_halt, is_illegal;
  logic       go_halt;
  state_t     end_state;
  logic       unused_ir_bits;

  assign opcode         = bus.ir[31:27];
  assign ra             = bus.ir[26:23];
  assign rb             = bus.ir[22:19];
  assign rc             = bus.ir[18:15];
  assign unused_ir_bits = ^bus.ir[14:0];

  assign is_alu     = (opcode <= 5'd11);
  assign is_muldiv  = (opcode == 5'd15) || (opcode == 5'd16);
  assign is_nop     = (opcode == 5'd26);
  assign is_halt    = (opcode == 5'd27);
  assign is_illegal = !(is_alu || is_muldiv || is_nop || is_halt);

  // A Stop seen on the closing edge of an instruction still counts, so the latch is bypassed here.
  assign go_halt   = stop_latched || bus.stop;
  assign end_state = go_halt ? HLT : T0;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RST;
      stop_latched <= 1'b0;
    end else begin
      state <= state_next;
      if (state != RST && bus.stop)
        stop_latched <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RST: state_next = T0;
      T0:  state_next = T1;
      T1:  state_next = T2;
      T2: begin
        if (is_nop)       state_next = end_state;
        else if (is_halt) state_next = HLT;
        else              state_next = T3;
      end
      T3:  state_next = is_illegal ? end_state : T4;
      T4:  state_next = T5;
      T5:  state_next = is_muldiv ? T6 : end_state;
      T6:  state_next = end_state;
      HLT: state_next = HLT;
      default: state_next = RST;
    endcase
  end

  logic [NUM_REGS-1:0] rin_d, rout_d;
  logic [OPW-1:0]      op_d;
  logic pc_out_d, mar_in_d, inc_pc_d, read_d, mdr_in_d, mdr_out_d, ir_in_d, y_in_d;
  logic zhigh_in_d, zlow_in_d, zhigh_out_d, zlow_out_d, hi_in_d, lo_in_d, run_d, illegal_d;

  // The ALU encoding is the opcode offset by one; it is only presented while operands are on the bus.
  always_comb begin
    rin_d       = '0;
    rout_d      = '0;
    op_d        = '0;
    pc_out_d    = 1'b0;
    mar_in_d    = 1'b0;
    inc_pc_d    = 1'b0;
    read_d      = 1'b0;
    mdr_in_d    = 1'b0;
    mdr_out_d   = 1'b0;
    ir_in_d     = 1'b0;
    y_in_d      = 1'b0;
    zhigh_in_d  = 1'b0;
    zlow_in_d   = 1'b0;
    zhigh_out_d = 1'b0;
    zlow_out_d  = 1'b0;
    hi_in_d     = 1'b0;
    lo_in_d     = 1'b0;
    run_d       = 1'b1;
    illegal_d   = 1'b0;
    case (state)
      T0: begin
        pc_out_d = 1'b1;
        mar_in_d = 1'b1;
        inc_pc_d = 1'b1;
      end
      T1: begin
        read_d   = 1'b1;
        mdr_in_d = 1'b1;
      end
      T2: begin
        mdr_out_d = 1'b1;
        ir_in_d   = 1'b1;
      end
      T3: begin
        if (is_illegal) begin
          illegal_d = 1'b1;
        end else if (is_muldiv) begin
          rout_d = onehot(ra);
          y_in_d = 1'b1;
        end else if (is_alu) begin
          rout_d = onehot(rb);
          y_in_d = 1'b1;
        end
      end
      T4: begin
        op_d      = OPW'(opcode) + OPW'(1);
        zlow_in_d = 1'b1;
        if (is_muldiv) begin
          rout_d     = onehot(rb);
          zhigh_in_d = 1'b1;
        end else begin
          rout_d = onehot(rc);
        end
      end
      T5: begin
        zlow_out_d = 1'b1;
        if (is_muldiv) lo_in_d = 1'b1;
        else           rin_d   = onehot(ra);
      end
      T6: begin
        zhigh_out_d = 1'b1;
        hi_in_d     = 1'b1;
      end
      HLT:     run_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.rin       = rin_d;
  assign bus.rout      = rout_d;
  assign bus.op        = op_d;
  assign bus.pc_out    = pc_out_d;
  assign bus.mar_in    = mar_in_d;
  assign bus.inc_pc    = inc_pc_d;
  assign bus.read      = read_d;
  assign bus.mdr_in    = mdr_in_d;
  assign bus.mdr_out   = mdr_out_d;
  assign bus.ir_in     = ir_in_d;
  assign bus.y_in      = y_in_d;
  assign bus.zhigh_in  = zhigh_in_d;
  assign bus.zlow_in   = zlow_in_d;
  assign bus.zhigh_out = zhigh_out_d;
  assign bus.zlow_out  = zlow_out_d;
  assign bus.hi_in     = hi_in_d;
  assign bus.lo_in     = lo_in_d;
  assign bus.run       = run_d;
  assign bus.illegal   = illegal_d;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer: one record per clock of expected strobes,
// plus hand-written HALT, Clear-mid-instruction and Stop-in-reset sequences.
module tb_control_sequencer;

  logic clk;
  logic rst_n;

  control_sequencer_if #(.NUM_REGS(16), .OPW(5)) bus ();

  control_sequencer #(.NUM_REGS(16), .OPW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        stop;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [13:0] strb;
    logic [4:0]  op;
    logic        run;
    logic        illegal;
  } vec_t;

  localparam logic [13:0] S_PCOUT = 14'h2000, S_MARIN = 14'h1000, S_INCPC = 14'h0800;
  localparam logic [13:0] S_READ  = 14'h0400, S_MDRIN = 14'h0200, S_MDROUT = 14'h0100;
  localparam logic [13:0] S_IRIN  = 14'h0080, S_YIN   = 14'h0040, S_ZHIN  = 14'h0020;
  localparam logic [13:0] S_ZLIN  = 14'h0010, S_ZHOUT = 14'h0008, S_ZLOUT = 14'h0004;
  localparam logic [13:0] S_HIIN  = 14'h0002, S_LOIN  = 14'h0001;

  localparam logic [31:0] IR_ROL  = 32'h5B320000;
  localparam logic [31:0] IR_MUL  = 32'h79180000;
  localparam logic [31:0] IR_DIV  = 32'h80000000;
  localparam logic [31:0] IR_ADD  = 32'h00000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;

  int errors = 0;
  int checks = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] ir, input logic stop, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [13:0] strb,
                              input logic [4:0] op, input logic run, input logic illegal);
    vec_t v;
    v.ir = ir; v.stop = stop; v.rin = rin; v.rout = rout;
    v.strb = strb; v.op = op; v.run = run; v.illegal = illegal;
    return v;
  endfunction

  function automatic vec_t rstVec();
    return mk(IR_ROL, 1'b0, 16'h0, 16'h0, 14'h0, 5'd0, 1'b1, 1'b0);
  endfunction

  function automatic vec_t hltVec(input logic [31:0] ir);
    return mk(ir, 1'b0, 16'h0, 16'h0, 14'h0, 5'd0, 1'b0, 1'b0);
  endfunction

  // The T0 record keeps the previous IR since the old instruction's last decision happens on that edge.
  task automatic pushFetch(input logic [31:0] prev_ir, input logic [31:0] ir);
    tbl.push_back(mk(prev_ir, 1'b0, 16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC, 5'd0, 1'b1, 1'b0));
    tbl.push_back(mk(ir,      1'b0, 16'h0, 16'h0, S_READ | S_MDRIN,           5'd0, 1'b1, 1'b0));
    tbl.push_back(mk(ir,      1'b0, 16'h0, 16'h0, S_MDROUT | S_IRIN,          5'd0, 1'b1, 1'b0));
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.ir   = v.ir;
    bus.stop = v.stop;
  endtask

  task automatic checkOutput(input string name, input vec_t v);
    logic [13:0] act;
    act = {bus.pc_out, bus.mar_in, bus.inc_pc, bus.read, bus.mdr_in, bus.mdr_out, bus.ir_in,
           bus.y_in, bus.zhigh_in, bus.zlow_in, bus.zhigh_out, bus.zlow_out, bus.hi_in, bus.lo_in};
    checks++;
    if (bus.rin !== v.rin || bus.rout !== v.rout || act !== v.strb || bus.op !== v.op ||
        bus.run !== v.run || bus.illegal !== v.illegal) begin
      errors++;
      $display("[TB] FAIL %s: got rin=%h rout=%h strb=%h op=%h run=%b illegal=%b, want rin=%h rout=%h strb=%h op=%h run=%b illegal=%b",
               name, bus.rin, bus.rout, act, bus.op, bus.run, bus.illegal,
               v.rin, v.rout, v.strb, v.op, v.run, v.illegal);
    end
  endtask

  task automatic stepCheck(input string name, input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    @(negedge clk);
    checkOutput(name, v);
  endtask

  // Called mid-cycle: asserts Clear, expects strobes to drop before any edge, then releases.
  task automatic doClear(input string name);
    rst_n = 1'b0;
    #1;
    checkOutput(name, rstVec());
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pushFetch(IR_ROL, IR_ROL);
    tbl.push_back(mk(IR_ROL, 0, 16'h0000, 16'h0040, S_YIN,            5'd0,  1, 0));
    tbl.push_back(mk(IR_ROL, 0, 16'h0000, 16'h0010, S_ZLIN,           5'd12, 1, 0));
    tbl.push_back(mk(IR_ROL, 0, 16'h0040, 16'h0000, S_ZLOUT,          5'd0,  1, 0));
    pushFetch(IR_ROL, IR_MUL);
    tbl.push_back(mk(IR_MUL, 0, 16'h0000, 16'h0004, S_YIN,            5'd0,  1, 0));
    tbl.push_back(mk(IR_MUL, 0, 16'h0000, 16'h0008, S_ZHIN | S_ZLIN,  5'd16, 1, 0));
    tbl.push_back(mk(IR_MUL, 0, 16'h0000, 16'h0000, S_ZLOUT | S_LOIN, 5'd0,  1, 0));
    tbl.push_back(mk(IR_MUL, 0, 16'h0000, 16'h0000, S_ZHOUT | S_HIIN, 5'd0,  1, 0));
    pushFetch(IR_MUL, IR_NOP);
    pushFetch(IR_NOP, IR_ILL);
    tbl.push_back(mk(IR_ILL, 0, 16'h0000, 16'h0000, 14'h0,            5'd0,  1, 1));
    pushFetch(IR_ILL, IR_ADD);
    tbl.push_back(mk(IR_ADD, 0, 16'h0000, 16'h0001, S_YIN,            5'd0,  1, 0));
    tbl.push_back(mk(IR_ADD, 0, 16'h0000, 16'h0001, S_ZLIN,           5'd1,  1, 0));
    tbl.push_back(mk(IR_ADD, 0, 16'h0001, 16'h0000, S_ZLOUT,          5'd0,  1, 0));
    pushFetch(IR_ADD, IR_DIV);
    tbl.push_back(mk(IR_DIV, 0, 16'h0000, 16'h0001, S_YIN,            5'd0,  1, 0));
    tbl.push_back(mk(IR_DIV, 0, 16'h0000, 16'h0001, S_ZHIN | S_ZLIN,  5'd17, 1, 0));
    tbl.push_back(mk(IR_DIV, 0, 16'h0000, 16'h0000, S_ZLOUT | S_LOIN, 5'd0,  1, 0));
    tbl.push_back(mk(IR_DIV, 0, 16'h0000, 16'h0000, S_ZHOUT | S_HIIN, 5'd0,  1, 0));
    pushFetch(IR_DIV, IR_ROL);
    tbl.push_back(mk(IR_ROL, 0, 16'h0000, 16'h0040, S_YIN,            5'd0,  1, 0));
    tbl.push_back(mk(IR_ROL, 0, 16'h0000, 16'h0010, S_ZLIN,           5'd12, 1, 0));
    tbl.push_back(mk(IR_ROL, 1, 16'h0040, 16'h0000, S_ZLOUT,          5'd0,  1, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(hltVec(IR_ROL));

    rst_n    = 1'b1;
    bus.ir   = IR_ROL;
    bus.stop = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", rstVec());
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      stepCheck($sformatf("tbl[%0d]", i), tbl[i]);

    doClear("clear_from_hlt");

    stepCheck("halt_t0", mk(IR_HALT, 0, 16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC, 5'd0, 1, 0));
    stepCheck("halt_t1", mk(IR_HALT, 0, 16'h0, 16'h0, S_READ | S_MDRIN,           5'd0, 1, 0));
    stepCheck("halt_t2", mk(IR_HALT, 0, 16'h0, 16'h0, S_MDROUT | S_IRIN,          5'd0, 1, 0));
    for (int i = 0; i < 22; i++)
      stepCheck($sformatf("halt_hold[%0d]", i), hltVec(IR_HALT));
    doClear("clear_from_halt");

    stepCheck("kill_t0", mk(IR_ROL, 0, 16'h0, 16'h0,    S_PCOUT | S_MARIN | S_INCPC, 5'd0,  1, 0));
    stepCheck("kill_t1", mk(IR_ROL, 0, 16'h0, 16'h0,    S_READ | S_MDRIN,           5'd0,  1, 0));
    stepCheck("kill_t2", mk(IR_ROL, 0, 16'h0, 16'h0,    S_MDROUT | S_IRIN,          5'd0,  1, 0));
    stepCheck("kill_t3", mk(IR_ROL, 0, 16'h0, 16'h0040, S_YIN,                      5'd0,  1, 0));
    stepCheck("kill_t4", mk(IR_ROL, 0, 16'h0, 16'h0010, S_ZLIN,                     5'd12, 1, 0));
    doClear("clear_in_t4");

    // Stop is high across the RST->T0 edge only; it must not halt the following NOP.
    stepCheck("rststop_t0", mk(IR_NOP, 1, 16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC, 5'd0, 1, 0));
    stepCheck("rststop_t1", mk(IR_NOP, 0, 16'h0, 16'h0, S_READ | S_MDRIN,           5'd0, 1, 0));
    stepCheck("rststop_t2", mk(IR_NOP, 0, 16'h0, 16'h0, S_MDROUT | S_IRIN,          5'd0, 1, 0));
    stepCheck("rststop_t0b", mk(IR_NOP, 0, 16'h0, 16'h0, S_PCOUT | S_MARIN | S_INCPC, 5'd0, 1, 0));
    stepCheck("rststop_t1b", mk(IR_NOP, 0, 16'h0, 16'h0, S_READ | S_MDRIN,           5'd0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
